// File: rtl/sbox_sched_pkg.sv
// ============================================================================
// Module   : sbox_sched_pkg
// Purpose  : Shared types and constants for the S-box issue scheduler:
//            scheduler state encoding, the per-beat tag carried alongside
//            the S-box pipeline, and the requester source encodings.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sbox_sched_pkg;

  // A 128-bit state is substituted as this many 32-bit beats.
  localparam int BEATS = 4;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  // Requester that owns a beat in flight.
  localparam logic SRC_KX = 1'b0;
  localparam logic SRC_RD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
  } state_t;

  // Travels with every beat through the S-box unit's latency.
  typedef struct packed {
    logic       valid;
    logic       src;
    logic [1:0] beat;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/sbox_sched_if.sv
// ============================================================================
// Module   : sbox_sched_if
// Purpose  : Bundles the key-expansion request, round request and shared
//            S-box unit signals of the scheduler.
// Ports    : kx_*  key-expansion SubWord request/response
//            rd_*  round SubBytes request/response
//            sb_*  beat stream to/from the shared S-box unit
// Modports : slave  - scheduler view
//            master - environment view (requesters and S-box unit)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sbox_sched_if;

  logic         kx_valid;
  logic [31:0]  kx_word;
  logic         kx_ready;
  logic         kx_done;
  logic [31:0]  kx_result;

  logic         rd_valid;
  logic [127:0] rd_state;
  logic         rd_ready;
  logic         rd_done;
  logic [127:0] rd_result;

  logic         sb_valid;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;

  modport slave (
    input  kx_valid, kx_word, rd_valid, rd_state, sb_out,
    output kx_ready, kx_done, kx_result,
    output rd_ready, rd_done, rd_result,
    output sb_valid, sb_in
  );

  modport master (
    output kx_valid, kx_word, rd_valid, rd_state, sb_out,
    input  kx_ready, kx_done, kx_result,
    input  rd_ready, rd_done, rd_result,
    input  sb_valid, sb_in
  );

endinterface

`default_nettype wire

// File: rtl/sbox_sched_tag_pipe.sv
// ============================================================================
// Module   : sbox_tag_pipe
// Purpose  : DEPTH-deep shift register of beat tags that mirrors the fixed
//            latency of the shared S-box unit, so that pop lines up with the
//            unit result of the beat pushed DEPTH cycles earlier.
// Ports    : clk, rst (async, active high)
//            push  tag of the beat issued this cycle
//            pop   tag of the beat whose result is on sb_out this cycle
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sbox_tag_pipe
  import sbox_sched_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  wire  logic clk,
  input  wire  logic rst,
  input  tag_t       push,
  output tag_t       pop
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign pop = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sbox_sched.sv
// ============================================================================
// Module   : sbox_sched
// Purpose  : Shares one pipelined 32-bit S-box unit between key expansion
//            (one SubWord per request) and the round datapath (SubBytes as
//            four 32-bit beats). Fixed priority kx over rd per issue slot;
//            every beat is tagged and its result steered on return.
// Ports    : clk   clock
//            rst   asynchronous active-high reset
//            bus   sbox_sched_if.slave (kx_*, rd_*, sb_* signals)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int SBOX_LAT = 3
) (
  input wire logic    clk,
  input wire logic    rst,
  sbox_sched_if.slave bus
);

  state_t       r_state;
  logic [1:0]   r_beat;
  logic [127:0] r_rd_buf;
  logic         r_rd_done;
  logic [127:0] r_rd_result;
  logic         r_kx_busy;
  logic         r_kx_done;
  logic [31:0]  r_kx_result;

  logic         w_kx_accept;
  logic         w_rd_issue;
  logic         w_sb_valid;
  logic [31:0]  w_rd_beat;
  tag_t         w_push;
  tag_t         w_pop;
  logic         w_kx_ret;
  logic         w_rd_ret;
  logic         w_rd_last;

  // kx issues in its accept cycle. Gating with rst keeps the issue port
  // quiet while reset is held even though kx_ready reads 1 then.
  assign w_kx_accept = bus.kx_valid & ~r_kx_busy & ~rst;
  assign w_rd_issue  = (r_state == ST_RD_ISSUE) & ~w_kx_accept;
  assign w_sb_valid  = w_kx_accept | w_rd_issue;
  assign w_rd_beat   = r_rd_buf[{r_beat, 5'd0} +: 32];

  assign w_push = '{
    valid: w_sb_valid,
    src:   w_kx_accept ? SRC_KX : SRC_RD,
    beat:  w_kx_accept ? 2'd0 : r_beat
  };

  sbox_tag_pipe #(
    .DEPTH (SBOX_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop)
  );

  assign w_kx_ret  = w_pop.valid & (w_pop.src == SRC_KX);
  assign w_rd_ret  = w_pop.valid & (w_pop.src == SRC_RD);
  assign w_rd_last = w_rd_ret & (w_pop.beat == LAST_BEAT);

  // Key-expansion side: one beat outstanding at most; the busy flag spans
  // issue through return, which also bounds kx to one issue per
  // SBOX_LAT+1 cycles and so guarantees rd forward progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx_busy   <= 1'b0;
      r_kx_done   <= 1'b0;
      r_kx_result <= '0;
    end else begin
      r_kx_done <= w_kx_ret;
      if (w_kx_ret) begin
        r_kx_result <= bus.sb_out;
      end
      if (w_kx_accept) begin
        r_kx_busy <= 1'b1;
      end else if (w_kx_ret) begin
        r_kx_busy <= 1'b0;
      end
    end
  end

  // Round side: issue four beats, then wait for the last one to return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_rd_buf    <= '0;
      r_rd_done   <= 1'b0;
      r_rd_result <= '0;
    end else begin
      r_rd_done <= w_rd_last;
      if (w_rd_ret) begin
        r_rd_result[{w_pop.beat, 5'd0} +: 32] <= bus.sb_out;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.rd_valid) begin
            r_rd_buf <= bus.rd_state;
            r_beat   <= '0;
            r_state  <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          if (w_rd_issue) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == LAST_BEAT) begin
              r_state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (w_rd_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.kx_ready  = ~r_kx_busy;
  assign bus.kx_done   = r_kx_done;
  assign bus.kx_result = r_kx_result;
  assign bus.rd_ready  = (r_state == ST_IDLE);
  assign bus.rd_done   = r_rd_done;
  assign bus.rd_result = r_rd_result;
  assign bus.sb_valid  = w_sb_valid;
  assign bus.sb_in     = w_kx_accept ? bus.kx_word :
                         (w_rd_issue ? w_rd_beat : 32'd0);

endmodule

`default_nettype wire

// File: tb/tb_sbox_sched.sv
// ============================================================================
// Module   : tb_sbox_sched
// Purpose  : Self-checking bench for sbox_sched with an AES S-box unit model
//            of fixed latency and a scoreboard of expected beats/results.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sbox_sched;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox_sched_if bus ();

  sbox_sched #(
    .SBOX_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference AES S-box ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) r = gmul(r, a);  // a^254 = inverse (0 -> 0)
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
          ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(w[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // ---------------- external S-box unit model ----------------
  logic [31:0] unit_pipe [LAT] = '{default: '0};

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) unit_pipe[i] <= unit_pipe[i-1];
    unit_pipe[0] <= bus.sb_in;
  end
  assign bus.sb_out = sub_word(unit_pipe[LAT-1]);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]  kx_q   [$];
  logic [127:0] rd_q   [$];
  logic [31:0]  beat_q [$];

  int kx_acc_cyc = -1, kx_done_cyc = -1;
  int rd_acc_cyc = -1, rd_done_cyc = -1;
  int rd_beat_cyc [4];
  int beat_idx = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.kx_valid && bus.kx_ready) begin
        kx_acc_cyc = cyc;
        check("kx_issue_valid", bus.sb_valid, 1);
        check("kx_issue_data", bus.sb_in, bus.kx_word);
        kx_q.push_back(sub_word(bus.kx_word));
      end else if (bus.sb_valid) begin
        if (beat_q.size() == 0) begin
          check("rd_beat_unexpected", 1, 0);
        end else begin
          check("rd_beat_data", bus.sb_in, beat_q.pop_front());
          if (beat_idx < 4) rd_beat_cyc[beat_idx] = cyc;
          beat_idx++;
        end
      end else begin
        check("sb_in_idle_zero", bus.sb_in, 0);
      end

      if (bus.rd_valid && bus.rd_ready) begin
        rd_acc_cyc = cyc;
        beat_idx   = 0;
        for (int k = 0; k < 4; k++) beat_q.push_back(bus.rd_state[32*k +: 32]);
        rd_q.push_back(sub_bytes(bus.rd_state));
      end

      if (bus.kx_done) begin
        kx_done_cyc = cyc;
        if (kx_q.size() == 0) check("kx_done_unexpected", 1, 0);
        else check("kx_result", bus.kx_result, kx_q.pop_front());
      end
      if (bus.rd_done) begin
        rd_done_cyc = cyc;
        if (rd_q.size() == 0) check("rd_done_unexpected", 1, 0);
        else check("rd_result", bus.rd_result, rd_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_kx(input logic [31:0] w);
    bit got = 1'b0;
    bus.kx_valid = 1'b1;
    bus.kx_word  = w;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = bus.kx_ready;
    end
    if (!got) check("kx_accept_timeout", 0, 1);
    tick();
    bus.kx_valid = 1'b0;
    bus.kx_word  = $urandom;
  endtask

  task automatic req_rd(input logic [127:0] s);
    bit got = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_state = s;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = bus.rd_ready;
    end
    if (!got) check("rd_accept_timeout", 0, 1);
    tick();
    bus.rd_valid = 1'b0;
    bus.rd_state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Returns just after the negedge on which the last outstanding job retired.
  task automatic drain();
    bit empty = 1'b0;
    for (int n = 0; n < 80 && !empty; n++) begin
      @(negedge clk);
      #1;
      empty = (kx_q.size() == 0) && (rd_q.size() == 0) && (beat_q.size() == 0);
    end
    if (!empty) check("drain_timeout", 0, 1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] s1, s2;
    bit got;

    // kx_valid held during reset: nothing may be issued
    bus.kx_valid = 1'b1;
    bus.kx_word  = 32'hDEADBEEF;
    bus.rd_valid = 1'b0;
    bus.rd_state = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sb_valid", bus.sb_valid, 0);
    check("rst_sb_in", bus.sb_in, 0);
    check("rst_kx_ready", bus.kx_ready, 1);
    check("rst_rd_ready", bus.rd_ready, 1);
    check("rst_kx_done", bus.kx_done, 0);
    check("rst_rd_done", bus.rd_done, 0);
    check("rst_kx_result", bus.kx_result, 0);
    check("rst_rd_result", bus.rd_result, 0);
    bus.kx_valid = 1'b0;
    tick();
    rst = 1'b0;

    // kx alone
    req_kx(32'h00000000);
    @(negedge clk);
    check("kx_ready_busy", bus.kx_ready, 0);
    drain();
    check("kx_alone_latency", kx_done_cyc - kx_acc_cyc, LAT + 1);
    check("kx_alone_value", bus.kx_result, 32'h63636363);
    check("kx_ready_on_done", bus.kx_ready, 1);

    // rd alone
    tick();
    req_rd({16{8'h53}});
    drain();
    check("rd_alone_latency", rd_done_cyc - rd_acc_cyc, LAT + 5);
    check("rd_alone_beat0_cyc", rd_beat_cyc[0] - rd_acc_cyc, 1);
    check("rd_alone_beat3_cyc", rd_beat_cyc[3] - rd_acc_cyc, 4);
    check("rd_alone_value", bus.rd_result, {16{8'hED}});
    check("rd_ready_on_done", bus.rd_ready, 1);

    // contention: kx accepted two cycles after rd
    tick();
    req_rd({16{8'h01}});
    tick();
    req_kx(32'h00000000);
    drain();
    check("cont_kx_offset", kx_acc_cyc - rd_acc_cyc, 2);
    check("cont_beat1_slip", rd_beat_cyc[1] - rd_acc_cyc, 3);
    check("cont_rd_latency", rd_done_cyc - rd_acc_cyc, LAT + 6);
    check("cont_rd_value", bus.rd_result, {16{8'h7C}});
    check("cont_kx_value", bus.kx_result, 32'h63636363);

    // back-to-back rd: second request waits with valid held high
    tick();
    s1 = rand128();
    s2 = rand128();
    bus.rd_valid = 1'b1;
    bus.rd_state = s1;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = bus.rd_ready;
    end
    tick();
    bus.rd_state = s2;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = bus.rd_ready;
    end
    #1;
    check("b2b_accept_on_done", rd_acc_cyc, rd_done_cyc);
    tick();
    bus.rd_valid = 1'b0;
    drain();
    check("b2b_second_value", bus.rd_result, sub_bytes(s2));

    // reset mid-job with rd and kx beats in flight
    tick();
    req_rd(rand128());
    req_kx($urandom);
    #2;
    rst = 1'b1;
    kx_q.delete();
    rd_q.delete();
    beat_q.delete();
    #1;
    check("midrst_kx_ready", bus.kx_ready, 1);
    check("midrst_rd_ready", bus.rd_ready, 1);
    check("midrst_sb_valid", bus.sb_valid, 0);
    check("midrst_kx_result", bus.kx_result, 0);
    check("midrst_rd_result", bus.rd_result, 0);
    check("midrst_done", {bus.kx_done, bus.rd_done}, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    req_rd(rand128());
    drain();
    check("post_rst_rd_latency", rd_done_cyc - rd_acc_cyc, LAT + 5);

    // simultaneous kx and rd accept in IDLE
    tick();
    bus.kx_valid = 1'b1;
    bus.kx_word  = $urandom;
    bus.rd_valid = 1'b1;
    bus.rd_state = rand128();
    @(negedge clk);
    #1;
    check("sim_kx_accepted", kx_acc_cyc, cyc);
    check("sim_rd_accepted", rd_acc_cyc, cyc);
    tick();
    bus.kx_valid = 1'b0;
    bus.rd_valid = 1'b0;
    drain();
    check("sim_beat0_cyc", rd_beat_cyc[0] - rd_acc_cyc, 1);
    check("sim_kx_latency", kx_done_cyc - kx_acc_cyc, LAT + 1);
    check("sim_rd_latency", rd_done_cyc - rd_acc_cyc, LAT + 5);

    // random overlapping traffic
    for (int it = 0; it < 6; it++) begin
      tick();
      req_rd(rand128());
      repeat ($urandom_range(0, 3)) tick();
      req_kx($urandom);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
